railgun_song_player: RTL and testbench

- Melody sequencer for the piano project that plays the "Only My Railgun" theme from a fixed 64-step note table.
- It steps through the table at a tempo set by `speed` and starts from a section selected by `pro`. `freq` transposes the melody by octave.
- It emits the current note code and the current step position; the downstream tone generator and display consume these.

---
 rtl/railgun_pkg.sv | 53 +++++
 rtl/railgun_step_timer.sv | 50 +++++
 rtl/railgun_song_player.sv | 81 ++++++++
 tb/tb_railgun_song_player.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/railgun_pkg.sv
// railgun_pkg
//   Shared definitions for the "Only My Railgun" melody sequencer:
//   - note-code layout (octave nibble / scale-degree nibble) and REST code
//   - section length used to turn the 2-bit section select into an address
//   - SONG_ROM, the 64-step melody table (4 sections of 16; entry 63 is REST)
//   - transpose_note(), the octave shift + clamp applied to every played note
package railgun_pkg;

  localparam logic [7:0] REST = 8'h00;

  localparam int OCT_MSB = 7;
  localparam int OCT_LSB = 4;
  localparam int DEG_MSB = 3;
  localparam int DEG_LSB = 0;

  localparam int SECTION_LEN = 16;

  // Each entry is {octave, degree}; octave 0 marks a rest.
  localparam logic [7:0] SONG_ROM [64] = '{
    // section 0
    8'h43, 8'h45, 8'h46, 8'h45, 8'h43, 8'h42, 8'h43, 8'h00,
    8'h43, 8'h45, 8'h46, 8'h51, 8'h47, 8'h46, 8'h45, 8'h00,
    // section 1
    8'h36, 8'h37, 8'h41, 8'h42, 8'h43, 8'h42, 8'h41, 8'h37,
    8'h36, 8'h35, 8'h36, 8'h00, 8'h23, 8'h25, 8'h26, 8'h00,
    // section 2
    8'h51, 8'h52, 8'h53, 8'h55, 8'h53, 8'h52, 8'h51, 8'h47,
    8'h51, 8'h53, 8'h55, 8'h61, 8'h63, 8'h61, 8'h55, 8'h00,
    // section 3
    8'h53, 8'h55, 8'h56, 8'h55, 8'h53, 8'h52, 8'h51, 8'h00,
    8'h71, 8'h67, 8'h65, 8'h63, 8'h61, 8'h57, 8'h51, 8'h00
  };

  // Shift the octave by (freq - 4) and clamp to 1..7. Signed 5-bit math keeps
  // the worst cases (1-4 = -3, 7+3 = 10) representable before the clamp.
  function automatic logic [7:0] transpose_note(input logic [7:0] note,
                                                input logic [2:0] freq);
    logic signed [4:0] oct;
    logic [7:0]        result;
    result = REST;
    if (note[OCT_MSB:OCT_LSB] != 4'd0) begin
      oct = $signed({1'b0, note[OCT_MSB:OCT_LSB]}) + $signed({2'b00, freq}) - 5'sd4;
      if (oct < 5'sd1) begin
        oct = 5'sd1;
      end else if (oct > 5'sd7) begin
        oct = 5'sd7;
      end
      result = {oct[3:0], note[DEG_MSB:DEG_LSB]};
    end
    return result;
  endfunction

endpackage

// File: rtl/railgun_step_timer.sv
// railgun_step_timer
//   Tempo timer. Counts clocks within the current step and raises `step`
//   for one cycle when the step has lasted (8 - speed) * TICK_DIV clocks.
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   enable in   1 = playing (count), 0 = idle (hold tick at 0)
//   speed  in   tempo, 0 = slowest (8 units/step) .. 7 = fastest (1 unit/step)
//   step   out  one-cycle pulse: the address should advance on this clock
module railgun_step_timer #(
  parameter int TICK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] speed,
  output logic       step
);

  localparam int TICK_W = (8 * TICK_DIV > 1) ? $clog2(8 * TICK_DIV) : 1;

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;
  logic [TICK_W-1:0] period_m1;

  // Using >= rather than == lets a mid-step speed-up end the step at once
  // instead of letting tick run past the new (shorter) period.
  always_comb begin
    period_m1 = TICK_W'((32'd8 - 32'(speed)) * 32'(TICK_DIV) - 32'd1);
    step      = 1'b0;
    tick_d    = '0;
    if (enable) begin
      if (tick_q >= period_m1) begin
        step   = 1'b1;
        tick_d = '0;
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/railgun_song_player.sv
// railgun_song_player
//   Melody sequencer: walks SONG_ROM at the selected tempo starting from the
//   selected section, and emits the transposed note code plus step address.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   counterE  in   0 = idle (silent, parked at section start), 1 = play
//   pro       in   start section; start address = pro * 16
//   speed     in   tempo, 0 slowest .. 7 fastest
//   freq      in   octave transpose, 4 = none (shift = freq - 4)
//   op        out  note code {octave, degree}, 8'h00 = rest
//   of        out  current step address, zero-extended
module railgun_song_player
  import railgun_pkg::*;
#(
  parameter int TICK_DIV = 2,
  parameter int SONG_LEN = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       counterE,
  input  logic [1:0] pro,
  input  logic [2:0] speed,
  input  logic [2:0] freq,
  output logic [7:0] op,
  output logic [7:0] of
);

  logic [5:0] addr_q, addr_d;
  logic [7:0] op_q, op_d;
  logic [7:0] of_q, of_d;
  logic [5:0] start_addr;
  logic       step;

  railgun_step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (counterE),
    .speed  (speed),
    .step   (step)
  );

  // pro is sampled only here, so a change while playing is seen at the next
  // wrap or the next idle cycle. Outputs lag addr by one clock.
  always_comb begin
    start_addr = 6'(pro) * 6'(SECTION_LEN);
    addr_d     = addr_q;
    op_d       = REST;
    of_d       = {2'b00, addr_q};
    if (!counterE) begin
      addr_d = start_addr;
    end else begin
      op_d = transpose_note(SONG_ROM[addr_q], freq);
      if (step) begin
        if (addr_q == 6'(SONG_LEN - 1)) begin
          addr_d = start_addr;
        end else begin
          addr_d = addr_q + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      op_q   <= REST;
      of_q   <= 8'h00;
    end else begin
      addr_q <= addr_d;
      op_q   <= op_d;
      of_q   <= of_d;
    end
  end

  assign op = op_q;
  assign of = of_q;

endmodule

// File: tb/tb_railgun_song_player.sv
// tb_railgun_song_player
//   Scoreboard bench. The driver sets inputs on each falling edge and pushes
//   the outputs a reference model predicts for the following rising edge; a
//   monitor pops and compares one entry just after each rising edge.
module tb_railgun_song_player;

  localparam int TICK_DIV = 2;

  // Independent copy of the melody: {octave, degree}, octave 0 = rest.
  localparam logic [7:0] TUNE [64] = '{
    8'h43, 8'h45, 8'h46, 8'h45, 8'h43, 8'h42, 8'h43, 8'h00,
    8'h43, 8'h45, 8'h46, 8'h51, 8'h47, 8'h46, 8'h45, 8'h00,
    8'h36, 8'h37, 8'h41, 8'h42, 8'h43, 8'h42, 8'h41, 8'h37,
    8'h36, 8'h35, 8'h36, 8'h00, 8'h23, 8'h25, 8'h26, 8'h00,
    8'h51, 8'h52, 8'h53, 8'h55, 8'h53, 8'h52, 8'h51, 8'h47,
    8'h51, 8'h53, 8'h55, 8'h61, 8'h63, 8'h61, 8'h55, 8'h00,
    8'h53, 8'h55, 8'h56, 8'h55, 8'h53, 8'h52, 8'h51, 8'h00,
    8'h71, 8'h67, 8'h65, 8'h63, 8'h61, 8'h57, 8'h51, 8'h00
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       counterE;
  logic [1:0] pro;
  logic [2:0] speed;
  logic [2:0] freq;
  logic [7:0] op;
  logic [7:0] of;

  typedef struct {
    logic [7:0] op;
    logic [7:0] of;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: current step index and clocks spent in it.
  int m_addr    = 0;
  int m_elapsed = 0;

  always #5 clk = ~clk;

  railgun_song_player #(
    .TICK_DIV (TICK_DIV),
    .SONG_LEN (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .counterE (counterE),
    .pro      (pro),
    .speed    (speed),
    .freq     (freq),
    .op       (op),
    .of       (of)
  );

  function automatic logic [7:0] ref_note(input int idx, input int f);
    logic [7:0] entry;
    int         o;
    entry = TUNE[idx];
    if (entry[7:4] == 4'd0) return 8'h00;
    o = int'(entry[7:4]) + f - 4;
    if (o < 1) o = 1;
    if (o > 7) o = 7;
    return 8'(o * 16 + int'(entry[3:0]));
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %02h, expected %02h", name, $time, act, req);
    end
  endtask

  // Predict the outputs of the coming rising edge from the inputs just driven.
  task automatic drive_cycle(input logic ce, input logic [1:0] p,
                             input logic [2:0] s, input logic [2:0] f);
    exp_t e;
    int   period;
    counterE = ce;
    pro      = p;
    speed    = s;
    freq     = f;
    e.of = 8'(m_addr);
    e.op = ce ? ref_note(m_addr, int'(f)) : 8'h00;
    sb_q.push_back(e);
    if (!ce) begin
      m_addr    = int'(p) * 16;
      m_elapsed = 0;
    end else begin
      period    = (8 - int'(s)) * TICK_DIV;
      m_elapsed = m_elapsed + 1;
      if (m_elapsed >= period) begin
        m_elapsed = 0;
        m_addr    = (m_addr == 63) ? int'(p) * 16 : m_addr + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic [1:0] p,
                               input logic [2:0] s, input logic [2:0] f,
                               input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      drive_cycle(ce, p, s, f);
    end
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock.
  task automatic pulse_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset op", op, 8'h00);
    checkOutput("async reset of", of, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    m_addr    = 0;
    m_elapsed = 0;
    drive_cycle(counterE, pro, speed, freq);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput("op", op, e.op);
      checkOutput("of", of, e.of);
    end
  end

  initial begin
    rst      = 1'b1;
    counterE = 1'b0;
    pro      = 2'd0;
    speed    = 3'd4;
    freq     = 3'd4;
    #2;
    checkOutput("reset op", op, 8'h00);
    checkOutput("reset of", of, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_cycle(1'b1, 2'd0, 3'd4, 3'd4);

    // Start and 8-clock step timing from address 0.
    applyStimulus(1'b1, 2'd0, 3'd4, 3'd4, 150);
    // One octave up.
    applyStimulus(1'b0, 2'd0, 3'd7, 3'd5, 2);
    applyStimulus(1'b1, 2'd0, 3'd7, 3'd5, 34);
    // Section 3 with wrap back to 48.
    applyStimulus(1'b0, 2'd3, 3'd7, 3'd4, 3);
    applyStimulus(1'b1, 2'd3, 3'd7, 3'd4, 44);
    // Clamp high and low.
    applyStimulus(1'b0, 2'd2, 3'd7, 3'd7, 2);
    applyStimulus(1'b1, 2'd2, 3'd7, 3'd7, 34);
    applyStimulus(1'b0, 2'd1, 3'd7, 3'd0, 2);
    applyStimulus(1'b1, 2'd1, 3'd7, 3'd0, 34);
    // Slowest tempo, then speed-up mid-step at tick 10.
    applyStimulus(1'b0, 2'd0, 3'd0, 3'd4, 2);
    applyStimulus(1'b1, 2'd0, 3'd0, 3'd4, 42);
    applyStimulus(1'b1, 2'd0, 3'd7, 3'd4, 6);
    // pro change while playing, then drop to idle.
    applyStimulus(1'b1, 2'd1, 3'd6, 3'd3, 20);
    applyStimulus(1'b0, 2'd1, 3'd5, 3'd4, 4);
    // Reset mid-play resumes from address 0.
    applyStimulus(1'b1, 2'd2, 3'd6, 3'd4, 9);
    pulse_reset();
    applyStimulus(1'b1, 2'd2, 3'd7, 3'd4, 20);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset();
      end else begin
        applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(1, 12)));
      end
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
